// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    KILL
  } fetch_state_e;

  // Fetch targets are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry instruction/pc holding register with valid/ready handshake to decode.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [31:0]        pc_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic [15:0]        imm16_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;

  // Flush wins over everything; a load only arrives while the entry is empty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= data_i;
      pc_q    <= pc_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign imm16_o = instr_q[15:0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: issues imem requests, tracks the PC and handles redirects.
// Optional FETCH_ALIGN_CHECK_EN adds fault_o for misaligned redirect targets.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic [15:0]        imm16_o,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               fault_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q;
  logic         buf_load, buf_flush;
  logic [31:0]  tgt;

  assign tgt = align_pc(redirect_pc_i);

  // pc_q is the next address to fetch; addr_q is the address on the bus, which
  // must stay put in KILL while pc_q already holds the redirect target.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_i) begin
          pc_d   = tgt;
          addr_d = tgt;
        end else begin
          addr_d = pc_q;
        end
      end
      REQ: begin
        if (redirect_i) begin
          pc_d = tgt;
          if (imem_ack_i) addr_d = tgt;
          else            state_d = KILL;
        end else if (imem_ack_i) begin
          buf_load = 1'b1;
          pc_d     = addr_q + PC_STEP;
          state_d  = VALID;
        end
      end
      VALID: begin
        if (redirect_i) begin
          buf_flush = 1'b1;
          pc_d      = tgt;
          addr_d    = tgt;
          state_d   = REQ;
        end else if (instr_ready_i) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      KILL: begin
        if (redirect_i) pc_d = tgt;
        if (imem_ack_i) begin
          addr_d  = redirect_i ? tgt : pc_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= (state_d == REQ) || (state_d == KILL);
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) fault_q <= 1'b0;
    else        fault_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
  end
  assign fault_o = fault_q;
`endif

  fetch_buf u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .flush_i (buf_flush),
    .data_i  (imem_data_i),
    .pc_i    (addr_q),
    .ready_i (instr_ready_i),
    .valid_o (instr_valid_o),
    .instr_o (instr_o),
    .pc_o    (pc_o),
    .imm16_o (imm16_o)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: handshake, stall, redirects, PC wrap and async reset.
module tb_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req, ack, valid, ready, redir;
  logic [31:0] addr, data, instr, pc, rpc;
  logic [15:0] imm;

  logic        rst2, req2, ack2, valid2;
  logic [31:0] addr2, instr2, pc2;
  logic [15:0] imm2;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault, fault2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  instr_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .instr_valid_o(valid), .instr_ready_i(ready), .instr_o(instr), .pc_o(pc),
    .imm16_o(imm), .redirect_i(redir), .redirect_pc_i(rpc)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fault_o(fault)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk_i(clk_i), .rst_i(rst2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_data_i(32'h5555_AAAA),
    .instr_valid_o(valid2), .instr_ready_i(1'b1), .instr_o(instr2), .pc_o(pc2),
    .imm16_o(imm2), .redirect_i(1'b0), .redirect_pc_i(32'h0)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fault_o(fault2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Entered just after the edge where the request went out; acks after dly cycles.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input int dly);
    chk("req_up", 32'(req), 32'd1);
    chk("req_addr", addr, a);
    for (int i = 1; i < dly; i++) begin
      tick();
      chk("addr_hold", addr, a);
    end
    ack  = 1'b1;
    data = d;
    tick();
    ack  = 1'b0;
    data = 32'h0;
    chk("valid_up", 32'(valid), 32'd1);
    chk("instr", instr, d);
    chk("pc", pc, a);
    chk("imm16", 32'(imm), {16'h0, d[15:0]});
    chk("req_drop", 32'(req), 32'd0);
  endtask

  initial begin
    rst_i = 1'b0; rst2 = 1'b0;
    ack = 1'b0; data = '0; ready = 1'b1; redir = 1'b0; rpc = '0; ack2 = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_imm", 32'(imm), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_fault", 32'(fault), 32'd0);
`endif

    // Straight-line fetch with ready high.
    rst_i = 1'b1;
    tick();
    fetch_one(32'h0, 32'h1111_0001, 2);
    tick();
    chk("accept_valid", 32'(valid), 32'd0);

    // Stall with ready low: outputs frozen, no new request.
    ready = 1'b0;
    fetch_one(32'h4, 32'h2001_00FF, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_instr", instr, 32'h2001_00FF);
      chk("stall_pc", pc, 32'h4);
      chk("stall_imm", 32'(imm), 32'h0000_00FF);
      chk("stall_noreq", 32'(req), 32'd0);
    end
    ready = 1'b1;
    tick();
    chk("post_stall_valid", 32'(valid), 32'd0);
    chk("post_stall_req", 32'(req), 32'd1);
    chk("post_stall_addr", addr, 32'h8);

    // Redirect while the request at 0x8 is unacked.
    redir = 1'b1; rpc = 32'h100;
    tick();
    redir = 1'b0;
    chk("kill_addr0", addr, 32'h8);
    chk("kill_req", 32'(req), 32'd1);
    tick(); chk("kill_addr1", addr, 32'h8);
    tick(); chk("kill_addr2", addr, 32'h8);
    ack = 1'b1; data = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0; data = '0;
    chk("kill_discard", 32'(valid), 32'd0);
    chk("kill_newaddr", addr, 32'h100);
    fetch_one(32'h100, 32'h0000_1234, 1);
    tick();

    // Redirect in VALID drops the held word; redirect with ack in REQ discards it.
    ready = 1'b0;
    fetch_one(32'h104, 32'hABCD_0001, 1);
    redir = 1'b1; rpc = 32'h200;
    tick();
    chk("vredir_valid", 32'(valid), 32'd0);
    chk("vredir_addr", addr, 32'h200);
    chk("vredir_req", 32'(req), 32'd1);
    ack = 1'b1; data = 32'hBAD0_0BAD; rpc = 32'h300;
    tick();
    ack = 1'b0; data = '0; redir = 1'b0;
    chk("rack_valid", 32'(valid), 32'd0);
    chk("rack_addr", addr, 32'h300);
    chk("rack_req", 32'(req), 32'd1);
    fetch_one(32'h300, 32'h0300_0003, 1);

    // Misaligned redirect together with a ready accept.
    ready = 1'b1; redir = 1'b1; rpc = 32'h102;
    tick();
    redir = 1'b0;
    chk("mis_valid", 32'(valid), 32'd0);
    chk("mis_addr", addr, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("fault_pulse", 32'(fault), 32'd1);
`endif
    tick();
    chk("mis_addr_hold", addr, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("fault_clear", 32'(fault), 32'd0);
`endif

    // Asynchronous reset while a request is outstanding.
    chk("pre_rst_req", 32'(req), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("async_req_drop", 32'(req), 32'd0);
    tick(); tick();
    rst_i = 1'b1;
    tick();
    chk("restart_req", 32'(req), 32'd1);
    chk("restart_addr", addr, 32'h0);

    // PC wrap from 0xFFFF_FFFC.
    rst2 = 1'b1;
    tick();
    chk("wrap_req0", 32'(req2), 32'd1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    chk("wrap_valid", 32'(valid2), 32'd1);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_instr", instr2, 32'h5555_AAAA);
    chk("wrap_imm", 32'(imm2), 32'h0000_AAAA);
    tick();
    chk("wrap_req1", 32'(req2), 32'd1);
    chk("wrap_addr1", addr2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
